// File: rtl/munoc_apb4_multi_port_bridge_if.sv
// ---------------------------------------------------------------------------
// munoc_apb4_multi_port_bridge_if
//
// Bundles every channel of the multi-port APB bridge into one interface:
//    - request channel      req_valid/req_ready, req_tid, req_write, req_addr,
//                           req_len, req_burst, req_prot
//    - write-data channel   wd_valid/wd_ready, wd_data, wd_strb, wd_last
//    - response channel     rsp_valid/rsp_ready, rsp_tid, rsp_write, rsp_data,
//                           rsp_resp, rsp_last
//    - APB4 completer bus   paddr, psel[NUM_PORT], penable, pwrite, pwdata,
//                           pstrb, pprot, prdata[NUM_PORT*BW_DATA],
//                           pready[NUM_PORT], pslverr[NUM_PORT]
//
// Modports:
//    master : the bridge itself (drives APB and responses, consumes requests)
//    slave  : the surrounding system (packetizer plus APB completers)
// ---------------------------------------------------------------------------
interface munoc_apb4_multi_port_bridge_if #(
   parameter int NUM_PORT = 4,
   parameter int BW_ADDR  = 32,
   parameter int BW_DATA  = 32,
   parameter int BW_TID   = 4
);
   localparam int BYTES = BW_DATA / 8;

   logic                         req_valid;
   logic                         req_ready;
   logic [BW_TID-1:0]            req_tid;
   logic                         req_write;
   logic [BW_ADDR-1:0]           req_addr;
   logic [7:0]                   req_len;
   logic [1:0]                   req_burst;
   logic [2:0]                   req_prot;

   logic                         wd_valid;
   logic                         wd_ready;
   logic [BW_DATA-1:0]           wd_data;
   logic [BYTES-1:0]             wd_strb;
   logic                         wd_last;

   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [BW_TID-1:0]            rsp_tid;
   logic                         rsp_write;
   logic [BW_DATA-1:0]           rsp_data;
   logic [1:0]                   rsp_resp;
   logic                         rsp_last;

   logic [BW_ADDR-1:0]           paddr;
   logic [NUM_PORT-1:0]          psel;
   logic                         penable;
   logic                         pwrite;
   logic [BW_DATA-1:0]           pwdata;
   logic [BYTES-1:0]             pstrb;
   logic [2:0]                   pprot;
   logic [NUM_PORT*BW_DATA-1:0]  prdata;
   logic [NUM_PORT-1:0]          pready;
   logic [NUM_PORT-1:0]          pslverr;

   modport master (
      input  req_valid, req_tid, req_write, req_addr, req_len, req_burst, req_prot,
      output req_ready,
      input  wd_valid, wd_data, wd_strb, wd_last,
      output wd_ready,
      output rsp_valid, rsp_tid, rsp_write, rsp_data, rsp_resp, rsp_last,
      input  rsp_ready,
      output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      input  prdata, pready, pslverr
   );

   modport slave (
      output req_valid, req_tid, req_write, req_addr, req_len, req_burst, req_prot,
      input  req_ready,
      output wd_valid, wd_data, wd_strb, wd_last,
      input  wd_ready,
      input  rsp_valid, rsp_tid, rsp_write, rsp_data, rsp_resp, rsp_last,
      output rsp_ready,
      input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/munoc_apb4_multi_port_bridge.sv
// ---------------------------------------------------------------------------
// munoc_apb4_multi_port_bridge
//
// Slave-side protocol engine of the MUNOC APB network interface. Takes the
// decoded request / write-data channels from the packetizer, splits each
// burst (FIXED / INCR / WRAP) into single APB4 transfers, routes every beat
// to one of NUM_PORT completers by an address field, enforces an access
// timeout and returns one response per read beat or one merged response per
// write burst. Exactly one APB transfer is in flight at any time.
//
// Ports:
//    clk           clock
//    rstnn         synchronous reset, active high (1 = reset)
//    comm_disable  blocks acceptance of new requests while 1
//    bus           bridge side (master modport) of all request, write-data,
//                  response and APB channels
//    busy          1 whenever the engine is not idle
// ---------------------------------------------------------------------------
module munoc_apb4_multi_port_bridge #(
   parameter int NUM_PORT       = 4,
   parameter int BW_ADDR        = 32,
   parameter int BW_DATA        = 32,
   parameter int BW_TID         = 4,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clk,
   input  logic                           rstnn,
   input  logic                           comm_disable,
   munoc_apb4_multi_port_bridge_if.master bus,
   output logic                           busy
);

   localparam int BYTES    = BW_DATA / 8;
   localparam int BW_SEL   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
   localparam int BW_UPPER = BW_ADDR - SEL_LSB;
   localparam int TOUT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [TOUT_W-1:0]   TOUT_LAST = TOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [BW_UPPER:0]   PORT_LIM  = (BW_UPPER + 1)'(NUM_PORT);

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_W,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [BW_TID-1:0]   cur_tid;
   logic                cur_write;
   logic [BW_ADDR-1:0]  cur_addr;
   logic [7:0]          cur_len;
   logic [1:0]          cur_burst;
   logic [2:0]          cur_prot;
   logic [7:0]          beat_cnt;
   logic [TOUT_W-1:0]   tout_cnt;
   logic [1:0]          wresp;
   logic [BW_DATA-1:0]  pwdata_q;
   logic [BYTES-1:0]    pstrb_q;
   logic [1:0]          rsp_resp_q;
   logic [BW_DATA-1:0]  rsp_data_q;
   logic                rsp_last_q;

   logic                req_fire;
   logic                apb_active;
   logic                cur_dec_ok;
   logic [BW_SEL-1:0]   sel;
   logic [NUM_PORT-1:0] sel_onehot;
   logic                pready_sel;
   logic                timed_out;
   logic                apb_done;
   logic [1:0]          apb_resp;
   logic [BW_DATA-1:0]  apb_rdata;
   logic                beat_last;
   logic                wd_mismatch;
   logic [1:0]          wd_wresp;
   logic [1:0]          acc_wresp;
   logic [BW_ADDR-1:0]  cur_addr_next;

   // A beat address is routable only when everything above the port-select
   // field names an existing port; any stray upper bit is a decode error.
   function automatic logic dec_ok(input logic [BW_ADDR-1:0] a);
      logic [BW_UPPER-1:0] upper;
      upper  = a[BW_ADDR-1:SEL_LSB];
      dec_ok = ({1'b0, upper} < PORT_LIM);
   endfunction

   // Address of the following beat. WRAP only wraps for 2/4/8/16-beat bursts;
   // the low bits inside the wrap window increment, the high bits are held.
   function automatic logic [BW_ADDR-1:0] next_addr(input logic [BW_ADDR-1:0] a,
                                                    input logic [7:0]         len,
                                                    input logic [1:0]         burst);
      logic [BW_ADDR-1:0] inc;
      logic [BW_ADDR-1:0] mask;
      inc       = a + BW_ADDR'(BYTES);
      mask      = BW_ADDR'((int'(len) + 1) * BYTES - 1);
      next_addr = inc;
      if (burst == BURST_FIXED) begin
         next_addr = a;
      end else if ((burst == BURST_WRAP) &&
                   ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
         next_addr = (a & ~mask) | (inc & mask);
      end
   endfunction

   // Response codes are ordered so that the numerically larger one is also
   // the more severe one (DECERR > SLVERR > OKAY).
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      resp_max = (a > b) ? a : b;
   endfunction

   // Beat-level decode, completion and response selection shared by the
   // next-state logic and the datapath.
   assign req_fire      = bus.req_valid & bus.req_ready;
   assign apb_active    = (state == ST_SETUP) || (state == ST_ACCESS);
   assign cur_dec_ok    = dec_ok(cur_addr);
   assign sel           = cur_addr[SEL_LSB +: BW_SEL];
   assign sel_onehot    = NUM_PORT'(1) << sel;
   assign pready_sel    = bus.pready[sel];
   assign timed_out     = (TIMEOUT_CYCLES != 0) && (tout_cnt == TOUT_LAST);
   assign apb_done      = (state == ST_ACCESS) && (pready_sel || timed_out);
   assign apb_resp      = pready_sel ? (bus.pslverr[sel] ? RESP_SLVERR : RESP_OKAY) : RESP_SLVERR;
   assign apb_rdata     = pready_sel ? bus.prdata[int'(sel) * BW_DATA +: BW_DATA] : '0;
   assign beat_last     = (beat_cnt == cur_len);
   assign wd_mismatch   = (bus.wd_last != beat_last);
   assign wd_wresp      = !cur_dec_ok ? RESP_DECERR
                                      : (wd_mismatch ? resp_max(wresp, RESP_SLVERR) : wresp);
   assign acc_wresp     = resp_max(wresp, apb_resp);
   assign cur_addr_next = next_addr(cur_addr, cur_len, cur_burst);

   // Handshake readies and outputs are all derived from the registered state,
   // so a reset forces every output low right after the reset edge. The
   // request ready is also held low while reset is applied.
   assign bus.req_ready = (state == ST_IDLE) && !comm_disable && !rstnn;
   assign bus.wd_ready  = (state == ST_WAIT_W);

   assign bus.psel      = apb_active ? sel_onehot : '0;
   assign bus.penable   = (state == ST_ACCESS);
   assign bus.paddr     = apb_active ? cur_addr : '0;
   assign bus.pwrite    = apb_active & cur_write;
   assign bus.pwdata    = (apb_active && cur_write) ? pwdata_q : '0;
   assign bus.pstrb     = (apb_active && cur_write) ? pstrb_q : '0;
   assign bus.pprot     = apb_active ? cur_prot : '0;

   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_tid   = (state == ST_RESP) ? cur_tid : '0;
   assign bus.rsp_write = (state == ST_RESP) & cur_write;
   assign bus.rsp_data  = (state == ST_RESP) ? rsp_data_q : '0;
   assign bus.rsp_resp  = (state == ST_RESP) ? rsp_resp_q : RESP_OKAY;
   assign bus.rsp_last  = (state == ST_RESP) & rsp_last_q;

   assign busy          = (state != ST_IDLE);

   // State register; reset aborts whatever transfer is in progress.
   always_ff @(posedge clk) begin
      if (rstnn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A beat whose address does not decode never visits
   // SETUP/ACCESS: it is completed with DECERR wherever it would have started
   // (request acceptance, write-data arrival or the previous read response).
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (req_fire) begin
               if (bus.req_write) begin
                  state_next = ST_WAIT_W;
               end else begin
                  state_next = dec_ok(bus.req_addr) ? ST_SETUP : ST_RESP;
               end
            end
         end
         ST_WAIT_W: begin
            if (bus.wd_valid) begin
               if (cur_dec_ok) begin
                  state_next = ST_SETUP;
               end else begin
                  state_next = beat_last ? ST_RESP : ST_WAIT_W;
               end
            end
         end
         ST_SETUP: begin
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb_done) begin
               state_next = (cur_write && !beat_last) ? ST_WAIT_W : ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               if (rsp_last_q) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = cur_dec_ok ? ST_SETUP : ST_RESP;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Transaction context and beat datapath. The address advances as soon as
   // a beat completes, so the decode for the next beat always looks at
   // cur_addr. Read beats only bump the beat counter once their response has
   // been taken; write beats bump it on completion.
   always_ff @(posedge clk) begin
      if (rstnn) begin
         cur_tid    <= '0;
         cur_write  <= 1'b0;
         cur_addr   <= '0;
         cur_len    <= '0;
         cur_burst  <= '0;
         cur_prot   <= '0;
         beat_cnt   <= '0;
         tout_cnt   <= '0;
         wresp      <= RESP_OKAY;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         rsp_resp_q <= RESP_OKAY;
         rsp_data_q <= '0;
         rsp_last_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  cur_tid    <= bus.req_tid;
                  cur_write  <= bus.req_write;
                  cur_addr   <= bus.req_addr;
                  cur_len    <= bus.req_len;
                  cur_burst  <= bus.req_burst;
                  cur_prot   <= bus.req_prot;
                  beat_cnt   <= '0;
                  wresp      <= RESP_OKAY;
                  pwdata_q   <= '0;
                  pstrb_q    <= '0;
                  rsp_resp_q <= RESP_OKAY;
                  rsp_data_q <= '0;
                  rsp_last_q <= 1'b0;
                  if (!bus.req_write && !dec_ok(bus.req_addr)) begin
                     cur_addr   <= next_addr(bus.req_addr, bus.req_len, bus.req_burst);
                     rsp_resp_q <= RESP_DECERR;
                     rsp_last_q <= (bus.req_len == 8'd0);
                  end
               end
            end
            ST_WAIT_W: begin
               if (bus.wd_valid) begin
                  pwdata_q <= bus.wd_data;
                  pstrb_q  <= bus.wd_strb;
                  wresp    <= wd_wresp;
                  if (!cur_dec_ok) begin
                     if (beat_last) begin
                        rsp_resp_q <= wd_wresp;
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
                     end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                        cur_addr <= cur_addr_next;
                     end
                  end
               end
            end
            ST_SETUP: begin
               tout_cnt <= '0;
            end
            ST_ACCESS: begin
               tout_cnt <= tout_cnt + TOUT_W'(1);
               if (apb_done) begin
                  if (cur_write) begin
                     wresp <= acc_wresp;
                     if (beat_last) begin
                        rsp_resp_q <= acc_wresp;
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
                     end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                        cur_addr <= cur_addr_next;
                     end
                  end else begin
                     rsp_resp_q <= apb_resp;
                     rsp_data_q <= apb_rdata;
                     rsp_last_q <= beat_last;
                     cur_addr   <= cur_addr_next;
                  end
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready && !rsp_last_q) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (!cur_dec_ok) begin
                     rsp_resp_q <= RESP_DECERR;
                     rsp_data_q <= '0;
                     rsp_last_q <= ((beat_cnt + 8'd1) == cur_len);
                     cur_addr   <= cur_addr_next;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_munoc_apb4_multi_port_bridge.sv
// ---------------------------------------------------------------------------
// tb_munoc_apb4_multi_port_bridge
//
// Directed bench for the multi-port APB bridge: four completer ports, an
// 8-cycle access timeout. Completer behaviour (pready, pslverr, prdata) is
// set step by step from the single stimulus sequence below; every expected
// value is written out by hand.
// ---------------------------------------------------------------------------
module tb_munoc_apb4_multi_port_bridge;

   localparam int NUM_PORT       = 4;
   localparam int BW_ADDR        = 32;
   localparam int BW_DATA        = 32;
   localparam int BW_TID         = 4;
   localparam int SEL_LSB        = 12;
   localparam int TIMEOUT_CYCLES = 8;

   logic        clk = 1'b0;
   logic        rstnn;
   logic        comm_disable;
   logic        busy;
   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] wrap_addr [4];

   munoc_apb4_multi_port_bridge_if #(
      .NUM_PORT (NUM_PORT),
      .BW_ADDR  (BW_ADDR),
      .BW_DATA  (BW_DATA),
      .BW_TID   (BW_TID)
   ) bus ();

   munoc_apb4_multi_port_bridge #(
      .NUM_PORT       (NUM_PORT),
      .BW_ADDR        (BW_ADDR),
      .BW_DATA        (BW_DATA),
      .BW_TID         (BW_TID),
      .SEL_LSB        (SEL_LSB),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .rstnn        (rstnn),
      .comm_disable (comm_disable),
      .bus          (bus),
      .busy         (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Advance one clock and land just after the edge, where outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and on a difference count and report it.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request for a single cycle (issued only while the bridge is idle).
   task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [3:0] tid);
      bus.req_valid = 1'b1;
      bus.req_write = write;
      bus.req_addr  = addr;
      bus.req_len   = len;
      bus.req_burst = burst;
      bus.req_tid   = tid;
      bus.req_prot  = 3'b010;
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Present one write-data beat for a single cycle (issued only in WAIT_W).
   task automatic sendBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
      bus.wd_valid = 1'b1;
      bus.wd_data  = data;
      bus.wd_strb  = strb;
      bus.wd_last  = last;
      tick();
      bus.wd_valid = 1'b0;
   endtask

   // Directed stimulus sequence.
   initial begin
      wrap_addr     = '{32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 32'h0000_0004};
      rstnn         = 1'b1;
      comm_disable  = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_burst = '0;
      bus.req_tid   = '0;
      bus.req_prot  = '0;
      bus.wd_valid  = 1'b0;
      bus.wd_data   = '0;
      bus.wd_strb   = '0;
      bus.wd_last   = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.prdata    = '0;
      bus.pready    = '0;
      bus.pslverr   = '0;

      $display("[TB] reset");
      repeat (3) tick();
      checkOutput("rst_busy",      busy,          1'b0);
      checkOutput("rst_psel",      bus.psel,      4'b0000);
      checkOutput("rst_penable",   bus.penable,   1'b0);
      checkOutput("rst_req_ready", bus.req_ready, 1'b0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
      rstnn = 1'b0;
      tick();
      checkOutput("idle_req_ready", bus.req_ready, 1'b1);

      $display("[TB] single read, port 1");
      bus.pready            = 4'b0010;
      bus.prdata[32 +: 32]  = 32'hDEAD_BEEF;
      bus.rsp_ready         = 1'b0;
      applyStimulus(1'b0, 32'h0000_1004, 8'd0, 2'd1, 4'd5);
      checkOutput("rd_setup_psel",    bus.psel,    4'b0010);
      checkOutput("rd_setup_penable", bus.penable, 1'b0);
      checkOutput("rd_setup_paddr",   bus.paddr,   32'h0000_1004);
      checkOutput("rd_setup_pprot",   bus.pprot,   3'b010);
      checkOutput("rd_setup_pwrite",  bus.pwrite,  1'b0);
      checkOutput("rd_setup_pstrb",   bus.pstrb,   4'h0);
      checkOutput("rd_busy",          busy,        1'b1);
      tick();
      checkOutput("rd_access_psel",    bus.psel,    4'b0010);
      checkOutput("rd_access_penable", bus.penable, 1'b1);
      tick();
      checkOutput("rd_resp_psel",  bus.psel,      4'b0000);
      checkOutput("rd_rsp_valid",  bus.rsp_valid, 1'b1);
      checkOutput("rd_rsp_data",   bus.rsp_data,  32'hDEAD_BEEF);
      checkOutput("rd_rsp_resp",   bus.rsp_resp,  2'd0);
      checkOutput("rd_rsp_last",   bus.rsp_last,  1'b1);
      checkOutput("rd_rsp_tid",    bus.rsp_tid,   4'd5);
      tick();
      checkOutput("rd_hold_valid", bus.rsp_valid, 1'b1);
      checkOutput("rd_hold_data",  bus.rsp_data,  32'hDEAD_BEEF);
      bus.rsp_ready = 1'b1;
      tick();
      checkOutput("rd_done_busy",  busy,          1'b0);
      checkOutput("rd_done_valid", bus.rsp_valid, 1'b0);

      $display("[TB] INCR write, 4 beats, error on beat 2");
      bus.pready = 4'b0011;
      applyStimulus(1'b1, 32'h0000_0000, 8'd3, 2'd1, 4'd9);
      for (int b = 0; b < 4; b++) begin
         checkOutput("wr_wd_ready", bus.wd_ready, 1'b1);
         sendBeat(32'h1111_0000 + 32'(b), 4'hF, (b == 3));
         checkOutput("wr_paddr",  bus.paddr,  32'(b * 4));
         checkOutput("wr_psel",   bus.psel,   4'b0001);
         checkOutput("wr_pwrite", bus.pwrite, 1'b1);
         checkOutput("wr_pwdata", bus.pwdata, 32'h1111_0000 + 32'(b));
         checkOutput("wr_pstrb",  bus.pstrb,  4'hF);
         bus.pslverr = (b == 2) ? 4'b0001 : 4'b0000;
         tick();
         checkOutput("wr_penable", bus.penable, 1'b1);
         tick();
         bus.pslverr = 4'b0000;
      end
      checkOutput("wr_rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("wr_rsp_resp",  bus.rsp_resp,  2'd2);
      checkOutput("wr_rsp_last",  bus.rsp_last,  1'b1);
      checkOutput("wr_rsp_write", bus.rsp_write, 1'b1);
      checkOutput("wr_rsp_data",  bus.rsp_data,  32'h0);
      checkOutput("wr_rsp_tid",   bus.rsp_tid,   4'd9);
      checkOutput("wr_rsp_psel",  bus.psel,      4'b0000);
      tick();
      checkOutput("wr_one_rsp", bus.rsp_valid, 1'b0);
      checkOutput("wr_idle",    busy,          1'b0);

      $display("[TB] decode error read");
      applyStimulus(1'b0, 32'h0000_5000, 8'd0, 2'd1, 4'd3);
      checkOutput("dec_psel",     bus.psel,      4'b0000);
      checkOutput("dec_penable",  bus.penable,   1'b0);
      checkOutput("dec_rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("dec_rsp_resp", bus.rsp_resp,  2'd3);
      checkOutput("dec_rsp_data", bus.rsp_data,  32'h0);
      checkOutput("dec_rsp_last", bus.rsp_last,  1'b1);
      tick();
      checkOutput("dec_idle", busy, 1'b0);

      $display("[TB] access timeout, port 2");
      bus.pready = 4'b0000;
      applyStimulus(1'b0, 32'h0000_2000, 8'd0, 2'd1, 4'd2);
      checkOutput("to_setup_psel", bus.psel, 4'b0100);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("to_penable", bus.penable, 1'b1);
      end
      tick();
      checkOutput("to_drop_penable", bus.penable,   1'b0);
      checkOutput("to_drop_psel",    bus.psel,      4'b0000);
      checkOutput("to_rsp_valid",    bus.rsp_valid, 1'b1);
      checkOutput("to_rsp_resp",     bus.rsp_resp,  2'd2);
      checkOutput("to_rsp_data",     bus.rsp_data,  32'h0);
      tick();
      checkOutput("to_req_ready", bus.req_ready, 1'b1);

      $display("[TB] WRAP read, 4 beats");
      bus.pready = 4'b0001;
      applyStimulus(1'b0, 32'h0000_0008, 8'd3, 2'd2, 4'd7);
      checkOutput("wrap_accepted", busy, 1'b1);
      for (int b = 0; b < 4; b++) begin
         checkOutput("wrap_paddr", bus.paddr, wrap_addr[b]);
         checkOutput("wrap_psel",  bus.psel,  4'b0001);
         bus.prdata[0 +: 32] = 32'hA5A5_0000 + 32'(b);
         tick();
         checkOutput("wrap_penable", bus.penable, 1'b1);
         tick();
         checkOutput("wrap_rsp_valid", bus.rsp_valid, 1'b1);
         checkOutput("wrap_rsp_data",  bus.rsp_data,  32'hA5A5_0000 + 32'(b));
         checkOutput("wrap_rsp_last",  bus.rsp_last,  (b == 3));
         checkOutput("wrap_rsp_resp",  bus.rsp_resp,  2'd0);
         tick();
      end
      checkOutput("wrap_idle", busy, 1'b0);

      $display("[TB] write with wd_last mismatch");
      applyStimulus(1'b1, 32'h0000_0000, 8'd0, 2'd1, 4'd1);
      sendBeat(32'h0000_00AA, 4'h3, 1'b0);
      checkOutput("mis_pstrb", bus.pstrb, 4'h3);
      tick();
      tick();
      checkOutput("mis_rsp_resp", bus.rsp_resp, 2'd2);
      checkOutput("mis_rsp_last", bus.rsp_last, 1'b1);
      tick();

      $display("[TB] comm_disable during a 2-beat write");
      bus.pready = 4'b0011;
      applyStimulus(1'b1, 32'h0000_1000, 8'd1, 2'd1, 4'd4);
      comm_disable = 1'b1;
      sendBeat(32'hCAFE_0000, 4'hF, 1'b0);
      checkOutput("cd_psel0",      bus.psel,      4'b0010);
      checkOutput("cd_req_ready0", bus.req_ready, 1'b0);
      tick();
      tick();
      checkOutput("cd_wd_ready", bus.wd_ready, 1'b1);
      sendBeat(32'hCAFE_0001, 4'hF, 1'b1);
      checkOutput("cd_paddr1", bus.paddr, 32'h0000_1004);
      tick();
      tick();
      checkOutput("cd_rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("cd_rsp_resp",  bus.rsp_resp,  2'd0);
      checkOutput("cd_rsp_last",  bus.rsp_last,  1'b1);
      tick();
      checkOutput("cd_idle",       busy,          1'b0);
      checkOutput("cd_req_ready1", bus.req_ready, 1'b0);
      comm_disable = 1'b0;
      #1;
      checkOutput("cd_req_ready2", bus.req_ready, 1'b1);

      $display("[TB] reset during ACCESS");
      bus.pready = 4'b0000;
      applyStimulus(1'b0, 32'h0000_1000, 8'd0, 2'd1, 4'd6);
      tick();
      checkOutput("mr_penable", bus.penable, 1'b1);
      rstnn = 1'b1;
      tick();
      checkOutput("mr_psel",      bus.psel,      4'b0000);
      checkOutput("mr_penable0",  bus.penable,   1'b0);
      checkOutput("mr_paddr",     bus.paddr,     32'h0);
      checkOutput("mr_busy",      busy,          1'b0);
      checkOutput("mr_rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("mr_req_ready", bus.req_ready, 1'b0);
      checkOutput("mr_wd_ready",  bus.wd_ready,  1'b0);
      rstnn = 1'b0;
      tick();
      checkOutput("mr_recover", bus.req_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
